// File: rtl/seg_scan_decoder.sv
// Read-back decoder for a multiplexed active-low 7-segment scan bus.
// Synchronises the bus, waits for each digit slot to hold steady, decodes the
// glyph back to a hex nibble and publishes a full frame once every slot is seen.
module seg_scan_decoder #(
  parameter int ANODES  = 4,
  parameter int SEG_7   = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ANODES-1:0]     anodes,
  input  logic [SEG_7-1:0]      segments,
  output logic [4*ANODES-1:0]   digits,
  output logic [ANODES-1:0]     dp,
  output logic [ANODES-1:0]     blank,
  output logic [ANODES-1:0]     bad,
  output logic                  frame_valid,
  output logic                  scan_lost
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = (ANODES > 1) ? $clog2(ANODES) : 1;
  localparam int ZW = $clog2(ANODES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  logic [ANODES-1:0] a1, a2, pa;
  logic [SEG_7-1:0]  s1, s2, ps;
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [TW-1:0]     tcnt;
  logic [ANODES-1:0] mask;
  logic [ANODES-1:0][3:0] sh_dig, m_dig, dig_q;
  logic [ANODES-1:0] sh_dp, sh_blk, sh_bad, m_dp, m_blk, m_bad;
  logic [ZW-1:0]     zeros;
  logic [SW-1:0]     slot;
  logic              valid, changed, cap;
  logic [6:0]        p;
  logic [3:0]        nib;
  logic              blk, bd;

  assign digits = dig_q;

  // Two-flop synchroniser plus a one-cycle-old copy for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= '1; a2 <= '1; pa <= '1;
      s1 <= '1; s2 <= '1; ps <= '1;
    end else begin
      a1 <= anodes;   a2 <= a1;  pa <= a2;
      s1 <= segments; s2 <= s1;  ps <= s2;
    end
  end

  // A slot is valid only when exactly one anode line is pulled low.
  always_comb begin
    zeros = '0;
    slot  = '0;
    for (int i = 0; i < ANODES; i++) begin
      if (!a2[i]) begin
        zeros = zeros + 1'b1;
        slot  = SW'(i);
      end
    end
    valid   = (zeros == ZW'(1));
    changed = (a2 != pa) || (s2 != ps);
  end

  // Glyph to nibble; all-off is blank, anything unrecognised is flagged bad.
  always_comb begin
    p   = ~s2[6:0];
    nib = 4'h0;
    blk = 1'b0;
    bd  = 1'b0;
    case (p)
      7'h3F: nib = 4'h0;  7'h06: nib = 4'h1;  7'h5B: nib = 4'h2;  7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;  7'h6D: nib = 4'h5;  7'h7D: nib = 4'h6;  7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;  7'h6F: nib = 4'h9;  7'h77: nib = 4'hA;  7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;  7'h5E: nib = 4'hD;  7'h79: nib = 4'hE;  7'h71: nib = 4'hF;
      7'h00: blk = 1'b1;
      default: bd = 1'b1;
    endcase
  end

  // Shadow contents with the current slot's decode merged in, for same-cycle publish.
  always_comb begin
    m_dig = sh_dig;
    m_dp  = sh_dp;
    m_blk = sh_blk;
    m_bad = sh_bad;
    m_dig[slot] = nib;
    m_dp[slot]  = ~s2[7];
    m_blk[slot] = blk;
    m_bad[slot] = bd;
  end

  // Settle FSM next state; capture fires the cycle the stable count reaches SETTLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid) begin state_n = S_SETTLE; cnt_n = CW'(1); end
      end
      S_SETTLE: begin
        if (!valid)       begin state_n = S_IDLE; cnt_n = '0; end
        else if (changed) cnt_n = CW'(1);
        else              cnt_n = cnt + 1'b1;
      end
      S_HOLD: begin
        if (!valid)       begin state_n = S_IDLE; cnt_n = '0; end
        else if (changed) begin state_n = S_SETTLE; cnt_n = CW'(1); end
      end
      default: begin state_n = S_IDLE; cnt_n = '0; end
    endcase
    if (state_n == S_SETTLE && cnt_n == CW'(SETTLE)) begin
      cap     = 1'b1;
      state_n = S_HOLD;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Shadow/mask capture, frame publish and scan-loss watchdog (capture beats timeout).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dig <= '0; sh_dp <= '0; sh_blk <= '0; sh_bad <= '0;
      dig_q  <= '0; dp    <= '0; blank  <= '0; bad    <= '0;
      mask <= '0; tcnt <= '0; frame_valid <= 1'b0; scan_lost <= 1'b1;
    end else begin
      frame_valid <= 1'b0;
      if (cap) begin
        sh_dig <= m_dig; sh_dp <= m_dp; sh_blk <= m_blk; sh_bad <= m_bad;
        tcnt      <= '0;
        scan_lost <= 1'b0;
        if (&(mask | ~a2)) begin
          mask        <= '0;
          frame_valid <= 1'b1;
          dig_q <= m_dig; dp <= m_dp; blank <= m_blk; bad <= m_bad;
        end else begin
          mask <= mask | ~a2;
        end
      end else begin
        if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + 1'b1;
        if (tcnt >= TW'(TIMEOUT - 1)) begin
          scan_lost <= 1'b1;
          mask      <= '0;
        end
      end
    end
  end
endmodule
